// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: sequences ADC conversions, averages 2^n results and publishes them with sticky error flags
module adc_seq_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_vcm,
    input  logic        rst_n,
    input  logic        cont_i,
    input  logic        trig_i,
    input  logic [2:0]  avg_log2_i,
    input  logic [15:0] period_i,
    input  logic [15:0] cfg1_i,
    input  logic [15:0] cfg2_i,
    output logic        start_conversion_o,
    output logic [15:0] config_1_o,
    output logic [15:0] config_2_o,
    input  logic [15:0] adc_result_i,
    input  logic        adc_finished_i,
    output logic [15:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o,
    input  logic        clr_flags_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] START       = 3'd1;
    localparam logic [2:0] WAIT_DONE   = 3'd2;
    localparam logic [2:0] ACCUM       = 3'd3;
    localparam logic [2:0] WAIT_PERIOD = 3'd4;
    localparam logic [2:0] PUBLISH     = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          fin_q;
    logic          fin_rise;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          to_set;
    logic [15:0]   result_q;
    logic [15:0]   period_q;
    logic [15:0]   period_cnt;
    logic [2:0]    avg_q;
    logic [22:0]   acc;
    logic [22:0]   acc_shift;
    logic [7:0]    conv_cnt;
    logic [7:0]    conv_nxt;
    logic          last_conv;
    logic          run_cont;
    logic          abort_q;
    logic          abort;
    logic          leave_idle;
    logic          pub;
    logic          ovr_set;
    logic          acc_clr;

    assign fin_rise   = adc_finished_i & ~fin_q;
    assign to_hit     = to_cnt >= TO_LAST;
    assign to_set     = (state == WAIT_DONE) & ~fin_rise & to_hit;
    assign conv_nxt   = conv_cnt + 8'd1;
    assign last_conv  = conv_nxt == (8'd1 << avg_q);
    assign abort      = abort_q | (run_cont & ~cont_i);
    assign leave_idle = (state == IDLE) & (cont_i | trig_i);
    assign pub        = state == PUBLISH;
    assign ovr_set    = pub & data_valid_o & ~data_ready_i;
    assign acc_clr    = (state_nxt == IDLE) | pub;
    assign acc_shift  = acc >> avg_q;

    assign start_conversion_o = state == START;
    assign busy_o             = state != IDLE;

    // next-state selection; an aborted continuous run still lets a pending conversion finish
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        state_nxt = (cont_i | trig_i) ? START : IDLE;
            START:       state_nxt = abort ? IDLE : WAIT_DONE;
            WAIT_DONE:   state_nxt = fin_rise ? ACCUM : (to_hit ? IDLE : WAIT_DONE);
            ACCUM:       state_nxt = abort ? IDLE : (last_conv ? PUBLISH : WAIT_PERIOD);
            WAIT_PERIOD: state_nxt = abort ? IDLE : ((period_cnt == '0) ? START : WAIT_PERIOD);
            PUBLISH:     state_nxt = cont_i ? WAIT_PERIOD : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // state register and ADC finished edge detector
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fin_q <= 1'b0;
        end else begin
            state <= state_nxt;
            fin_q <= adc_finished_i;
        end
    end

    // configuration snapshot taken when a measurement or run begins
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            config_1_o <= '0;
            config_2_o <= '0;
            avg_q      <= '0;
            period_q   <= '0;
        end else if (leave_idle) begin
            config_1_o <= cfg1_i;
            config_2_o <= cfg2_i;
            avg_q      <= avg_log2_i;
            period_q   <= period_i;
        end
    end

    // run mode tracking: a run is continuous when cont_i started it or kept it going past a publish
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            run_cont <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            run_cont <= (leave_idle | pub) ? cont_i : run_cont;
            abort_q  <= (state == IDLE) ? 1'b0 : (abort_q | (run_cont & ~cont_i));
        end
    end

    // start-to-start period counter; loaded two short to absorb the START and reload-compare cycles
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= (state == START) ? ((period_q > 16'd2) ? period_q - 16'd2 : '0)
                        : ((period_cnt != '0) ? period_cnt - 16'd1 : '0);
        end
    end

    // conversion watchdog counts cycles since the start pulse
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= (state == START) ? TW'(1) : ((state == WAIT_DONE) ? to_cnt + TW'(1) : to_cnt);
        end
    end

    // result capture on the finished edge and accumulation of conversions
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            acc      <= '0;
            conv_cnt <= '0;
        end else begin
            result_q <= (state == WAIT_DONE && fin_rise) ? adc_result_i : result_q;
            acc      <= acc_clr ? '0 : ((state == ACCUM) ? acc + {7'd0, result_q} : acc);
            conv_cnt <= acc_clr ? '0 : ((state == ACCUM) ? conv_nxt : conv_cnt);
        end
    end

    // output register with valid/ready handshake; a publish wins over a same-cycle accept
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_o       <= pub ? acc_shift[15:0] : data_o;
            data_valid_o <= pub | (data_valid_o & ~data_ready_i);
        end
    end

    // sticky error flags; a set event beats a same-cycle clear
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            overrun_o <= ovr_set | (overrun_o & ~clr_flags_i);
            timeout_o <= to_set | (timeout_o & ~clr_flags_i);
        end
    end

endmodule
